riscv_memsplit_ctrl: RTL and testbench
======================================

// Module: riscv_memsplit_ctrl
// PURPOSE
//  Sequences CPU data accesses onto an XLEN-wide memory port. Accesses that fit in one
//  aligned XLEN word issue as a single beat with byte enables. Accesses that cross a word
//  boundary split into two aligned beats, with load data merged. Sits between the
//  LSU/misalignment check and the AHB-Lite bus interface.
// PARAMETERS
//  XLEN  64  data/word width in bits (32 or 64); W = XLEN/8 bytes per beat
//  PLEN  64  physical address width
// PORTS
//  clk_i        in   1        clock, rising edge
//  rst_i        in   1        synchronous, active-high reset
//  req_i        in   1        CPU access request
//  rdy_o        out  1        controller idle; req_i accepted when req_i&rdy_o
//  adr_i        in   PLEN     byte address
//  size_i       in   3        BYTE=0 HWORD=1 WORD=2 DWORD=3; others illegal
//  we_i         in   1        1=store, 0=load
//  d_i          in   XLEN     store data, right-aligned
//  ack_o        out  1        one-cycle completion pulse
//  err_o        out  1        valid with ack_o: illegal size or bus error
//  q_o          out  XLEN     load data, right-aligned, zero-filled above N bytes; valid with ack_o
//  mem_req_o    out  1        beat request, held until mem_ack_i
//  mem_adr_o    out  PLEN     word-aligned beat address (low log2(W) bits 0)
//  mem_we_o     out  1        beat write enable
//  mem_be_o     out  W        beat byte enables
//  mem_d_o      out  XLEN     beat store data
//  mem_ack_i    in   1        beat complete
//  mem_err_i    in   1        beat error, qualified by mem_ack_i
//  mem_q_i      in   XLEN     beat read data, qualified by mem_ack_i
// BEHAVIOUR
//  Reset values: state=IDLE, rdy_o=1, ack_o=0, err_o=0, mem_req_o=0, mem_be_o=0, q_o=0.
//  N = 1<<size_i; off = adr_i mod W; split = (off+N > W). Sizes are legal if N <= W.
//  DWORD is illegal when XLEN=32.
//  FSM states: IDLE, BEAT0, BEAT1, RESP.
//   IDLE: rdy_o=1. On req_i, capture adr/size/we/d.
//    - Illegal size: go to RESP with err. No bus beat is issued.
//    - Legal size: go to BEAT0.
//   BEAT0: mem_req_o=1, adr = adr_i & ~(W-1).
//    - Beat bytes: be = ((1<<N)-1)<<off truncated to W bits; d = d_i<<8*off.
//    - On mem_ack_i: capture mem_q_i to q0.
//    - If mem_err_i, go to RESP with err.
//    - Else if split, go to BEAT1; otherwise go to RESP.
//   BEAT1: mem_req_o=1, adr = beat0 adr + W, modulo 2^PLEN (wraps to 0 at top).
//    - Beat bytes: be = ((1<<N)-1)>>(W-off); d = d_i>>8*(W-off).
//    - On mem_ack_i: capture q1, then go to RESP (err if mem_err_i).
//   RESP: ack_o=1 for exactly one cycle, err_o as set, then go to IDLE.
//  Load data assembly:
//    - q_o = ((q0>>8*off) | (q1<<8*(W-off) if split)), masked to N bytes.
//    - Stores drive q_o=0.
//  Bus signals: mem_adr_o/be/we/d are registered and stable while mem_req_o=1.
//   mem_req_o drops in the cycle after the accepting mem_ack_i unless the next state is BEAT1,
//   in which case it stays high and the beat fields change. No back-to-back gaps are needed.
//  Latency with zero-wait bus: single beat = accept T, beat T+1, ack_o T+3; split ack_o T+4.
//  rdy_o=0 outside IDLE; req_i is ignored there. ack_o never coincides with rdy_o-accept.
//  Bus error on beat0 of a split access: beat1 is not issued.
//  Reset mid-operation:
//    - Next cycle IDLE, mem_req_o=0; no ack_o for the aborted access.
//    - Bus-side protocol cleanup is the bus interface's responsibility.
//  mem_ack_i while not in BEAT0/BEAT1 is ignored.
// TESTING (XLEN=64, W=8)
//  1 Aligned load WORD adr=0x1004, mem_q_i=0x89ABCDEF_01234567 -> one beat adr=0x1000
//    be=0xF0; q_o=0x89ABCDEF, ack_o at T+3.
//  2 Split store DWORD adr=0x2005 d=0x1122334455667788.
//    -> beat0 adr=0x2000 be=0xE0 d[63:40]=0x667788.
//    -> beat1 adr=0x2008 be=0x1F d[39:0]=0x1122334455; one ack_o.
//  3 Split load HWORD adr=0x3007, q0[63:56]=0xAB, q1[7:0]=0xCD -> q_o=0xCDAB, err_o=0.
//  4 size_i=5 and (XLEN=32) size_i=3 -> no mem_req_o; ack_o=1 err_o=1 two cycles after accept.
//  5 Split load, mem_err_i on beat0 -> beat1 never requested; ack_o=1 err_o=1.
//    Separately, 3 wait states on each beat -> mem fields stable throughout.
//  6 rst_i pulsed while in BEAT1 -> mem_req_o=0 and rdy_o=1 next cycle, no ack_o;
//    wrap case DWORD adr=0xFFFF_FFFF_FFFF_FFFC -> beat1 adr=0.

Source files
------------

// File: rtl/riscv_memsplit_ctrl.sv
// Sequences CPU data accesses onto an aligned XLEN-wide memory port: one beat when the
// access fits in a word, two aligned beats with merged load data when it crosses a word.
module riscv_memsplit_ctrl #(
  parameter int XLEN = 64,
  parameter int PLEN = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  output logic              rdy_o,
  input  logic [PLEN-1:0]   adr_i,
  input  logic [2:0]        size_i,
  input  logic              we_i,
  input  logic [XLEN-1:0]   d_i,
  output logic              ack_o,
  output logic              err_o,
  output logic [XLEN-1:0]   q_o,
  output logic              mem_req_o,
  output logic [PLEN-1:0]   mem_adr_o,
  output logic              mem_we_o,
  output logic [XLEN/8-1:0] mem_be_o,
  output logic [XLEN-1:0]   mem_d_o,
  input  logic              mem_ack_i,
  input  logic              mem_err_i,
  input  logic [XLEN-1:0]   mem_q_i
);

  localparam int W    = XLEN / 8;
  localparam int OFFW = $clog2(W);
  localparam logic [2:0] MAX_SIZE = 3'(OFFW);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

  state_t state, next_state;

  logic [PLEN-1:0]   adr_q;
  logic [2:0]        size_q;
  logic              we_q;
  logic [XLEN-1:0]   d_q;
  logic [XLEN-1:0]   q0_q;
  logic [XLEN-1:0]   q1_q;
  logic              err_q;

  logic [PLEN-1:0]   src_adr;
  logic [2:0]        src_size;
  logic [XLEN-1:0]   src_d;
  logic [OFFW-1:0]   src_off;
  logic [W-1:0]      n_lanes;
  logic [2*W-1:0]    lanes;
  logic [2*XLEN-1:0] d_shift;
  logic [XLEN-1:0]   q_keep;
  logic [XLEN-1:0]   q_load;
  logic              legal;
  logic              split;
  logic              accept;

  assign rdy_o  = (state == IDLE) && !ack_o;
  assign accept = req_i && rdy_o;

  // Lane arithmetic is shared: in IDLE it looks at the incoming request so beat 0 can be
  // registered on the accepting edge; afterwards it works from the captured copy.
  always_comb begin
    src_adr  = (state == IDLE) ? adr_i  : adr_q;
    src_size = (state == IDLE) ? size_i : size_q;
    src_d    = (state == IDLE) ? d_i    : d_q;
    src_off  = src_adr[OFFW-1:0];
    legal    = (src_size <= MAX_SIZE);
    n_lanes  = ~({W{1'b1}} << (32'd1 << src_size));
    lanes    = {{W{1'b0}}, n_lanes} << src_off;
    split    = |lanes[2*W-1:W];
    d_shift  = {{XLEN{1'b0}}, src_d} << {src_off, 3'b000};
    q_keep   = ~({XLEN{1'b1}} << (32'd8 << src_size));
    q_load   = q_keep & XLEN'({(split ? q1_q : {XLEN{1'b0}}), q0_q} >> {src_off, 3'b000});
  end

  // NOTE: sequential state uses <= so every flop samples the values from before the edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    // NOTE: default first, so no path through the case leaves next_state unassigned (no latch).
    next_state = state;
    case (state)
      IDLE:    if (accept)    next_state = legal ? BEAT0 : RESP;
      BEAT0:   if (mem_ack_i) next_state = (mem_err_i || !split) ? RESP : BEAT1;
      BEAT1:   if (mem_ack_i) next_state = RESP;
      RESP:                   next_state = IDLE;
      default:                next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q     <= 1'b0;
      ack_o     <= 1'b0;
      err_o     <= 1'b0;
      q_o       <= '0;
      mem_req_o <= 1'b0;
      mem_adr_o <= '0;
      mem_we_o  <= 1'b0;
      mem_be_o  <= '0;
      mem_d_o   <= '0;
    end else begin
      ack_o <= (state == RESP);
      err_o <= (state == RESP) && err_q;
      if (state == RESP) q_o <= (we_q || err_q) ? '0 : q_load;

      if (accept)
        err_q <= !legal;
      else if ((state == BEAT0 || state == BEAT1) && mem_ack_i)
        err_q <= mem_err_i;

      // Beat fields only move on a beat transition, so they hold steady across wait states.
      mem_req_o <= (next_state == BEAT0) || (next_state == BEAT1);
      if (state == IDLE && next_state == BEAT0) begin
        mem_adr_o <= {src_adr[PLEN-1:OFFW], {OFFW{1'b0}}};
        mem_we_o  <= we_i;
        mem_be_o  <= lanes[W-1:0];
        mem_d_o   <= d_shift[XLEN-1:0];
      end else if (state == BEAT0 && next_state == BEAT1) begin
        mem_adr_o <= mem_adr_o + PLEN'(W);
        mem_be_o  <= lanes[2*W-1:W];
        mem_d_o   <= d_shift[2*XLEN-1:XLEN];
      end else if (next_state != BEAT0 && next_state != BEAT1) begin
        mem_be_o  <= '0;
      end
    end
  end

  // NOTE: payload registers carry no reset; each is written before anything reads it.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      adr_q  <= adr_i;
      size_q <= size_i;
      we_q   <= we_i;
      d_q    <= d_i;
    end
    if (state == BEAT0 && mem_ack_i) q0_q <= mem_q_i;
    if (state == BEAT1 && mem_ack_i) q1_q <= mem_q_i;
  end

endmodule

// File: tb/tb_riscv_memsplit_ctrl.sv
// Self-checking bench for riscv_memsplit_ctrl (XLEN=64): byte-addressed memory responder
// plus a byte-level reference model of which lanes each access touches.
module tb_riscv_memsplit_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_i = 1'b0;
  logic        rdy_o;
  logic [63:0] adr_i = '0;
  logic [2:0]  size_i = '0;
  logic        we_i = 1'b0;
  logic [63:0] d_i = '0;
  logic        ack_o;
  logic        err_o;
  logic [63:0] q_o;
  logic        mem_req_o;
  logic [63:0] mem_adr_o;
  logic        mem_we_o;
  logic [7:0]  mem_be_o;
  logic [63:0] mem_d_o;
  logic        mem_ack_i = 1'b0;
  logic        mem_err_i = 1'b0;
  logic [63:0] mem_q_i = '0;

  riscv_memsplit_ctrl #(.XLEN(64), .PLEN(64)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .rdy_o(rdy_o), .adr_i(adr_i),
    .size_i(size_i), .we_i(we_i), .d_i(d_i), .ack_o(ack_o), .err_o(err_o), .q_o(q_o),
    .mem_req_o(mem_req_o), .mem_adr_o(mem_adr_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_d_o(mem_d_o), .mem_ack_i(mem_ack_i), .mem_err_i(mem_err_i), .mem_q_i(mem_q_i)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [63:0] adr;
    logic [7:0]  be;
    logic        we;
    logic [63:0] d;
  } beat_t;

  beat_t       beats[$];
  logic [7:0]  mem [logic [63:0]];
  int          wait_states = 0;
  int          err_on_beat = -1;
  int          beat_idx = 0;
  int          req_cycles = 0;
  int          unstable = 0;
  int          wait_cnt = 0;
  bit          in_beat = 0;
  logic [136:0] held;

  // ---------------- reference model ----------------
  function automatic logic [7:0] mem_rd(input logic [63:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ a[15:8] ^ 8'h5a;
  endfunction

  function automatic int n_bytes(input logic [2:0] size);
    return 1 << size;
  endfunction

  function automatic logic [63:0] model_load(input logic [63:0] adr, input logic [2:0] size);
    logic [63:0] q;
    q = '0;
    for (int i = 0; i < n_bytes(size); i++) q[8*i +: 8] = mem_rd(adr + 64'(i));
    return q;
  endfunction

  function automatic logic [63:0] byte_mask(input logic [2:0] size);
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < n_bytes(size); i++) m[8*i +: 8] = 8'hff;
    return m;
  endfunction

  function automatic int model_nbeats(input logic [63:0] adr, input logic [2:0] size);
    logic [63:0] first, last;
    first = adr & ~64'h7;
    last  = (adr + 64'(n_bytes(size) - 1)) & ~64'h7;
    return (first == last) ? 1 : 2;
  endfunction

  function automatic logic [63:0] model_word(input logic [63:0] adr, input int k);
    return (adr & ~64'h7) + 64'(8 * k);
  endfunction

  function automatic logic [7:0] model_be(input logic [63:0] adr, input logic [2:0] size,
                                          input int k);
    logic [63:0] a;
    logic [7:0]  be;
    be = '0;
    for (int i = 0; i < n_bytes(size); i++) begin
      a = adr + 64'(i);
      if ((a & ~64'h7) == model_word(adr, k)) be[a[2:0]] = 1'b1;
    end
    return be;
  endfunction

  // ---------------- memory responder ----------------
  always @(posedge clk_i) begin
    #1;
    mem_ack_i = 1'b0;
    mem_err_i = 1'b0;
    mem_q_i   = '0;
    if (mem_req_o) begin
      req_cycles++;
      if (!in_beat) begin
        in_beat  = 1;
        wait_cnt = 0;
        held     = {mem_adr_o, mem_be_o, mem_we_o, mem_d_o};
      end else if (held !== {mem_adr_o, mem_be_o, mem_we_o, mem_d_o}) begin
        unstable++;
      end
      if (wait_cnt < wait_states) begin
        wait_cnt++;
      end else begin
        mem_ack_i = 1'b1;
        mem_err_i = (beat_idx == err_on_beat);
        beats.push_back('{adr: mem_adr_o, be: mem_be_o, we: mem_we_o, d: mem_d_o});
        beat_idx++;
        in_beat = 0;
        for (int j = 0; j < 8; j++) begin
          if (mem_we_o) begin
            if (mem_be_o[j]) mem[mem_adr_o + 64'(j)] = mem_d_o[8*j +: 8];
          end else begin
            mem_q_i[8*j +: 8] = mem_rd(mem_adr_o + 64'(j));
          end
        end
      end
    end else begin
      in_beat = 0;
    end
  end

  // ---------------- driver ----------------
  task automatic do_access(input logic [63:0] adr, input logic [2:0] size, input logic we,
                           input logic [63:0] d, output logic [63:0] q, output logic err,
                           output int lat);
    int n;
    beats.delete();
    beat_idx   = 0;
    req_cycles = 0;
    @(negedge clk_i);
    n = 0;
    while (!rdy_o && n < 20) begin @(negedge clk_i); n++; end
    checks++;
    if (!rdy_o) begin errors++; $display("FAIL rdy_timeout: got rdy=%b expected 1", rdy_o); end
    req_i = 1'b1; adr_i = adr; size_i = size; we_i = we; d_i = d;
    @(negedge clk_i);
    req_i = 1'b0; adr_i = {$urandom, $urandom}; d_i = {$urandom, $urandom};
    size_i = 3'($urandom); we_i = 1'($urandom);
    lat = 1;
    while (!ack_o && lat < 200) begin @(negedge clk_i); lat++; end
    q = q_o;
    err = err_o;
    checks++;
    if (ack_o !== 1'b1) begin
      errors++; $display("FAIL ack_timeout: got ack=%b expected 1", ack_o);
    end else begin
      checks++;
      if (rdy_o !== 1'b0) begin errors++; $display("FAIL ack_with_rdy: got rdy=%b expected 0", rdy_o); end
      @(negedge clk_i);
      checks++;
      if (ack_o !== 1'b0) begin errors++; $display("FAIL ack_pulse: got ack=%b expected 0", ack_o); end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    checks++; if (rdy_o !== 1'b1)     begin errors++; $display("FAIL rst_rdy: got %b expected 1", rdy_o); end
    checks++; if (ack_o !== 1'b0)     begin errors++; $display("FAIL rst_ack: got %b expected 0", ack_o); end
    checks++; if (err_o !== 1'b0)     begin errors++; $display("FAIL rst_err: got %b expected 0", err_o); end
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL rst_mem_req: got %b expected 0", mem_req_o); end
    checks++; if (mem_be_o !== 8'h00) begin errors++; $display("FAIL rst_mem_be: got %h expected 00", mem_be_o); end
    checks++; if (q_o !== 64'h0)      begin errors++; $display("FAIL rst_q: got %h expected 0", q_o); end
    rst_i = 1'b0;
  endtask

  task automatic test_aligned_load();
    logic [63:0] w, q;
    logic err;
    int lat;
    w = 64'h89ABCDEF_01234567;
    for (int j = 0; j < 8; j++) mem[64'h1000 + 64'(j)] = w[8*j +: 8];
    do_access(64'h1004, 3'd2, 1'b0, 64'h0, q, err, lat);
    checks++; if (beats.size() != 1) begin errors++; $display("FAIL al_nbeats: got %0d expected 1", beats.size()); end
    else begin
      checks++; if (beats[0].adr !== 64'h1000) begin errors++; $display("FAIL al_adr: got %h expected 1000", beats[0].adr); end
      checks++; if (beats[0].be !== 8'hF0) begin errors++; $display("FAIL al_be: got %h expected f0", beats[0].be); end
      checks++; if (beats[0].we !== 1'b0) begin errors++; $display("FAIL al_we: got %b expected 0", beats[0].we); end
    end
    checks++; if (q !== 64'h89ABCDEF) begin errors++; $display("FAIL al_q: got %h expected 89abcdef", q); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL al_err: got %b expected 0", err); end
    checks++; if (lat != 3) begin errors++; $display("FAIL al_latency: got %0d expected 3", lat); end
  endtask

  task automatic test_split_store();
    logic [63:0] q;
    logic err;
    int lat;
    do_access(64'h2005, 3'd3, 1'b1, 64'h11223344_55667788, q, err, lat);
    checks++; if (beats.size() != 2) begin errors++; $display("FAIL ss_nbeats: got %0d expected 2", beats.size()); end
    else begin
      checks++; if (beats[0].adr !== 64'h2000) begin errors++; $display("FAIL ss_adr0: got %h expected 2000", beats[0].adr); end
      checks++; if (beats[0].be !== 8'hE0) begin errors++; $display("FAIL ss_be0: got %h expected e0", beats[0].be); end
      checks++; if (beats[0].d[63:40] !== 24'h667788) begin errors++; $display("FAIL ss_d0: got %h expected 667788", beats[0].d[63:40]); end
      checks++; if (beats[1].adr !== 64'h2008) begin errors++; $display("FAIL ss_adr1: got %h expected 2008", beats[1].adr); end
      checks++; if (beats[1].be !== 8'h1F) begin errors++; $display("FAIL ss_be1: got %h expected 1f", beats[1].be); end
      checks++; if (beats[1].d[39:0] !== 40'h1122334455) begin errors++; $display("FAIL ss_d1: got %h expected 1122334455", beats[1].d[39:0]); end
    end
    checks++; if (model_load(64'h2005, 3'd3) !== 64'h11223344_55667788) begin errors++; $display("FAIL ss_mem: got %h expected 1122334455667788", model_load(64'h2005, 3'd3)); end
    checks++; if (q !== 64'h0) begin errors++; $display("FAIL ss_q: got %h expected 0", q); end
    checks++; if (lat != 4) begin errors++; $display("FAIL ss_latency: got %0d expected 4", lat); end
  endtask

  task automatic test_split_load();
    logic [63:0] q;
    logic err;
    int lat;
    mem[64'h3007] = 8'hAB;
    mem[64'h3008] = 8'hCD;
    do_access(64'h3007, 3'd1, 1'b0, 64'h0, q, err, lat);
    checks++; if (q !== 64'hCDAB) begin errors++; $display("FAIL sl_q: got %h expected cdab", q); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL sl_err: got %b expected 0", err); end
    checks++; if (beats.size() != 2) begin errors++; $display("FAIL sl_nbeats: got %0d expected 2", beats.size()); end
    checks++; if (lat != 4) begin errors++; $display("FAIL sl_latency: got %0d expected 4", lat); end
  endtask

  task automatic test_illegal_size();
    logic [63:0] q;
    logic err;
    int lat;
    for (int s = 4; s < 8; s++) begin
      do_access(64'h1000 + 64'(s), 3'(s), 1'($urandom), {$urandom, $urandom}, q, err, lat);
      checks++; if (req_cycles != 0) begin errors++; $display("FAIL il_mem_req size=%0d: got %0d cycles expected 0", s, req_cycles); end
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL il_err size=%0d: got %b expected 1", s, err); end
      checks++; if (lat != 2) begin errors++; $display("FAIL il_latency size=%0d: got %0d expected 2", s, lat); end
    end
  endtask

  task automatic test_bus_error();
    logic [63:0] q;
    logic err;
    int lat;
    err_on_beat = 0;
    do_access(64'h4003, 3'd3, 1'b0, 64'h0, q, err, lat);
    checks++; if (req_cycles != 1) begin errors++; $display("FAIL be0_req_cycles: got %0d expected 1", req_cycles); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL be0_err: got %b expected 1", err); end
    checks++; if (lat != 3) begin errors++; $display("FAIL be0_latency: got %0d expected 3", lat); end
    err_on_beat = 1;
    do_access(64'h4003, 3'd3, 1'b0, 64'h0, q, err, lat);
    checks++; if (beats.size() != 2) begin errors++; $display("FAIL be1_nbeats: got %0d expected 2", beats.size()); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL be1_err: got %b expected 1", err); end
    err_on_beat = -1;
  endtask

  task automatic test_wait_states();
    logic [63:0] q, d;
    logic err;
    int lat;
    wait_states = 3;
    unstable = 0;
    d = {$urandom, $urandom};
    do_access(64'h5006, 3'd3, 1'b1, d, q, err, lat);
    checks++; if (lat != 10) begin errors++; $display("FAIL ws_latency: got %0d expected 10", lat); end
    checks++; if (model_load(64'h5006, 3'd3) !== d) begin errors++; $display("FAIL ws_mem: got %h expected %h", model_load(64'h5006, 3'd3), d); end
    do_access(64'h5006, 3'd3, 1'b0, 64'h0, q, err, lat);
    checks++; if (q !== d) begin errors++; $display("FAIL ws_q: got %h expected %h", q, d); end
    checks++; if (unstable != 0) begin errors++; $display("FAIL ws_stable: got %0d changes expected 0", unstable); end
    wait_states = 0;
  endtask

  task automatic test_reset_mid();
    int n;
    bit seen;
    beats.delete();
    beat_idx = 0;
    wait_states = 4;
    @(negedge clk_i);
    req_i = 1'b1; adr_i = 64'h6004; size_i = 3'd3; we_i = 1'b0; d_i = '0;
    @(negedge clk_i);
    req_i = 1'b0;
    n = 0;
    while (beats.size() == 0 && n < 50) begin @(negedge clk_i); n++; end
    @(negedge clk_i);
    checks++;
    if (mem_req_o !== 1'b1 || mem_adr_o !== 64'h6008) begin
      errors++; $display("FAIL rm_in_beat1: got req=%b adr=%h expected req=1 adr=6008", mem_req_o, mem_adr_o);
    end
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL rm_mem_req: got %b expected 0", mem_req_o); end
    checks++; if (rdy_o !== 1'b1) begin errors++; $display("FAIL rm_rdy: got %b expected 1", rdy_o); end
    seen = ack_o;
    repeat (8) begin @(negedge clk_i); if (ack_o) seen = 1; end
    checks++; if (seen) begin errors++; $display("FAIL rm_no_ack: got ack=1 expected 0"); end
    wait_states = 0;
  endtask

  task automatic test_wrap();
    logic [63:0] q, d;
    logic err;
    int lat;
    d = 64'hA1B2C3D4_E5F60718;
    do_access(64'hFFFF_FFFF_FFFF_FFFC, 3'd3, 1'b1, d, q, err, lat);
    checks++; if (beats.size() != 2) begin errors++; $display("FAIL wr_nbeats: got %0d expected 2", beats.size()); end
    else begin
      checks++; if (beats[0].adr !== 64'hFFFF_FFFF_FFFF_FFF8) begin errors++; $display("FAIL wr_adr0: got %h expected fffffffffffffff8", beats[0].adr); end
      checks++; if (beats[1].adr !== 64'h0) begin errors++; $display("FAIL wr_adr1: got %h expected 0", beats[1].adr); end
      checks++; if (beats[1].be !== 8'h0F) begin errors++; $display("FAIL wr_be1: got %h expected 0f", beats[1].be); end
    end
    do_access(64'hFFFF_FFFF_FFFF_FFFC, 3'd3, 1'b0, 64'h0, q, err, lat);
    checks++; if (q !== d) begin errors++; $display("FAIL wr_q: got %h expected %h", q, d); end
  endtask

  task automatic test_random();
    logic [63:0] adr, d, q, exp_q;
    logic [2:0]  size;
    logic        we, err;
    int lat, exp_lat, nb, r;
    bit legal;
    for (int it = 0; it < 80; it++) begin
      r = $urandom_range(0, 9);
      size = (r < 8) ? 3'(r % 4) : 3'(4 + $urandom_range(0, 3));
      legal = (size < 4);
      adr = (it % 10 == 9) ? (64'hFFFF_FFFF_FFFF_FFF8 | 64'($urandom_range(0, 7)))
                           : {32'h0, $urandom} ^ 64'($urandom_range(0, 7));
      we = 1'($urandom);
      d = {$urandom, $urandom};
      wait_states = $urandom_range(0, 2);
      exp_q = legal ? model_load(adr, size) : 64'h0;
      nb = legal ? model_nbeats(adr, size) : 0;
      exp_lat = !legal ? 2 : (nb == 1) ? 3 + wait_states : 4 + 2 * wait_states;
      do_access(adr, size, we, d, q, err, lat);
      checks++; if (err !== !legal) begin errors++; $display("FAIL rnd_err it=%0d: got %b expected %b", it, err, !legal); end
      checks++; if (lat != exp_lat) begin errors++; $display("FAIL rnd_latency it=%0d: got %0d expected %0d", it, lat, exp_lat); end
      checks++;
      if (beats.size() != nb) begin
        errors++; $display("FAIL rnd_nbeats it=%0d: got %0d expected %0d", it, beats.size(), nb);
      end else begin
        for (int k = 0; k < nb; k++) begin
          checks++;
          if (beats[k].adr !== model_word(adr, k) || beats[k].be !== model_be(adr, size, k) ||
              beats[k].we !== we) begin
            errors++;
            $display("FAIL rnd_beat it=%0d k=%0d: got adr=%h be=%h we=%b expected adr=%h be=%h we=%b",
                     it, k, beats[k].adr, beats[k].be, beats[k].we, model_word(adr, k),
                     model_be(adr, size, k), we);
          end
        end
      end
      if (legal && we) begin
        checks++;
        if (model_load(adr, size) !== (d & byte_mask(size))) begin
          errors++; $display("FAIL rnd_store it=%0d: got %h expected %h", it, model_load(adr, size), d & byte_mask(size));
        end
        checks++; if (q !== 64'h0) begin errors++; $display("FAIL rnd_store_q it=%0d: got %h expected 0", it, q); end
      end else if (legal) begin
        checks++; if (q !== exp_q) begin errors++; $display("FAIL rnd_load it=%0d: got %h expected %h", it, q, exp_q); end
      end
    end
    wait_states = 0;
  endtask

  initial begin
    test_reset();
    test_aligned_load();
    test_split_store();
    test_split_load();
    test_illegal_size();
    test_bus_error();
    test_wait_states();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
